// File: rtl/data_mem_ctrl_if.sv
// Request/response bus of the data memory controller.
// master: the requester (core or bench); slave: data_mem_ctrl.
// Both channels use valid/ready. A transfer happens on a rising edge where
// valid and ready are both high. Once valid is raised, the payload stays
// stable until that edge.
interface data_mem_ctrl_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic [2:0]            req_func3;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_rdata;
    logic                  resp_fault;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_func3, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_func3, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Single-port data memory controller with RISC-V style sub-word access.
// Request -> optional wait states -> held response. Stores commit and loads
// are captured on the edge entering RESP.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned half/word
// accesses fault instead of being forced aligned).
module data_mem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_WIDTH  = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_ctrl_if.slave bus,
    output logic [1:0]     dbg_state
);
    localparam int         IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [2:0]            func3_q, func3_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  fault_q, fault_d;

    logic [31:0] mem [DEPTH_WORDS];

    // Active request: live bus inputs in IDLE (zero-wait path), else latched copy
    logic                  cur_we;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [31:0]           cur_wdata;
    logic [2:0]            cur_func3;
    logic [IDX_W-1:0]      cur_idx;
    logic                  unused_addr_bits;

    logic        illegal;
    logic        misaligned;
    logic        access_fault;
    logic [3:0]  be;
    logic [31:0] wdata_lane;
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;
    logic        enter_resp;
    logic        mem_we;

    // Select the request being executed this cycle
    always_comb begin
        cur_we    = we_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        cur_func3 = func3_q;
        if (state_q == S_IDLE) begin
            cur_we    = bus.req_we;
            cur_addr  = bus.req_addr;
            cur_wdata = bus.req_wdata;
            cur_func3 = bus.req_func3;
        end
    end

    assign cur_idx          = cur_addr[IDX_W+1:2];
    assign unused_addr_bits = ^cur_addr[ADDR_WIDTH-1:IDX_W+2];

    // Decode access legality, byte enables, store lanes and load extension
    always_comb begin
        illegal = (cur_func3 == 3'd3) || (cur_func3[2:1] == 2'b11)
                  || (cur_we && cur_func3[2]);
`ifdef DMEM_MISALIGN_TRAP_EN
        misaligned = ((cur_func3[1:0] == 2'd1) && cur_addr[0])
                     || ((cur_func3[1:0] == 2'd2) && (cur_addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
        access_fault = illegal || misaligned;

        case (cur_func3[1:0])
            2'd0: begin
                be         = 4'b0001 << cur_addr[1:0];
                wdata_lane = {4{cur_wdata[7:0]}};
            end
            2'd1: begin
                be         = cur_addr[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{cur_wdata[15:0]}};
            end
            default: begin
                be         = 4'b1111;
                wdata_lane = cur_wdata;
            end
        endcase

        rd_word = mem[cur_idx];
        case (cur_addr[1:0])
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];

        case (cur_func3)
            3'd0:    load_data = {{24{rd_byte[7]}}, rd_byte};
            3'd1:    load_data = {{16{rd_half[15]}}, rd_half};
            3'd2:    load_data = rd_word;
            3'd4:    load_data = {24'd0, rd_byte};
            3'd5:    load_data = {16'd0, rd_half};
            default: load_data = 32'd0;
        endcase
        if (cur_we || access_fault) begin
            load_data = 32'd0;
        end
    end

    // FSM next state, request latch and response capture
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        func3_d    = func3_q;
        rdata_d    = rdata_q;
        fault_d    = fault_q;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    func3_d = bus.req_func3;
                    if (WS != 4'd0) begin
                        state_d = S_WAIT;
                        cnt_d   = WS - 4'd1;
                    end else begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = 32'd0;
                    fault_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (enter_resp) begin
            rdata_d = load_data;
            fault_d = access_fault;
        end
    end

    assign mem_we = enter_resp && cur_we && !access_fault;

    // State and request registers; everything here clears on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            func3_q <= 3'd0;
            rdata_q <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            func3_q <= func3_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    // Byte-lane store into the array; contents survive reset, a reset drops the pending write
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[cur_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_fault = fault_q;
    assign dbg_state      = state_q;
endmodule
